// File: rtl/fib_arb_pkg.sv
// Shared types for the Fibonacci engine arbiter: FSM states and response error codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package fib_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STROBE,
      S_SETTLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_RANGE   = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after last_grant, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx,
   output logic                       any_req
);

   localparam int IDX_W = $clog2(NUM_REQ);

   int               idx;
   logic [IDX_W-1:0] sel;

   // Scan from the farthest offset down so the nearest hit is the one that sticks.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      idx       = 0;
      sel       = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         sel = IDX_W'(idx);
         if (req[sel]) begin
            grant      = '0;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci engine among NUM_REQ requesters with round-robin grants, range check and busy watchdog.
// Latency: grant G, strobe G+1, response G+4 at the earliest (G+1 for range errors).
// Backpressure: req_ready only in IDLE; one job in flight, others hold req_valid until granted.
module fib_arbiter
   import fib_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int N_WIDTH   = 8,
   parameter int RES_WIDTH = 8,
   parameter int MAX_N     = 13,
   parameter int TIMEOUT   = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*N_WIDTH-1:0]   req_n,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [RES_WIDTH-1:0]         rsp_result,
   output logic [1:0]                   rsp_err,
   output logic                         eng_strobe,
   output logic [N_WIDTH-1:0]           eng_n,
   input  logic                         eng_busy,
   input  logic [RES_WIDTH-1:0]         eng_result
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t               state, state_nxt;
   logic [IDX_W-1:0]     last_grant, grant_idx;
   logic [NUM_REQ-1:0]   grant, win_q;
   logic                 any_req;
   logic [N_WIDTH-1:0]   n_arr [NUM_REQ];
   logic [N_WIDTH-1:0]   win_n;
   logic                 range_err;
   logic [CNT_W-1:0]     wait_cnt, wait_cnt_inc;
   logic                 timed_out;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_req    (any_req)
   );

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign n_arr[i] = req_n[i*N_WIDTH +: N_WIDTH];
   end

   assign win_n        = n_arr[grant_idx];
   assign range_err    = win_n > N_WIDTH'(MAX_N);
   assign wait_cnt_inc = wait_cnt + CNT_W'(1);
   assign timed_out    = wait_cnt_inc == CNT_W'(TIMEOUT);

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      eng_strobe = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = grant;
            if (any_req) state_nxt = range_err ? S_RESP : S_STROBE;
         end
         S_STROBE: begin
            eng_strobe = 1'b1;
            state_nxt  = S_SETTLE;
         end
         S_SETTLE: state_nxt = S_WAIT;
         S_WAIT:   if (!eng_busy || timed_out) state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         win_q      <= '0;
         eng_n      <= '0;
         wait_cnt   <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_err    <= ERR_OK;
      end else begin
         state     <= state_nxt;
         rsp_valid <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  last_grant <= grant_idx;
                  win_q      <= grant;
                  // Out-of-range jobs never reach the engine, so eng_n keeps its last legal value.
                  if (range_err) begin
                     rsp_valid  <= grant;
                     rsp_result <= '0;
                     rsp_err    <= ERR_RANGE;
                  end else begin
                     eng_n <= win_n;
                  end
               end
            end
            S_SETTLE: wait_cnt <= '0;
            S_WAIT: begin
               wait_cnt <= wait_cnt_inc;
               if (!eng_busy) begin
                  rsp_valid  <= win_q;
                  rsp_result <= eng_result;
                  rsp_err    <= ERR_OK;
               end else if (timed_out) begin
                  rsp_valid  <= win_q;
                  rsp_result <= '0;
                  rsp_err    <= ERR_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed scoreboard bench for fib_arbiter: a normal-engine DUT and a TIMEOUT=8 DUT with a stuck engine.
module tb_fib_arbiter;
   import fib_arb_pkg::*;

   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]   req_valid = '0;
   logic [NR*8-1:0] req_n     = '0;
   logic [NR-1:0]   req_ready, rsp_valid;
   logic [7:0]      rsp_result, eng_n;
   logic [7:0]      eng_result = '0;
   logic [1:0]      rsp_err;
   logic            eng_strobe;
   logic            eng_busy = 1'b0;
   logic [7:0]      eng_rem  = '0;

   logic [NR-1:0]   t_req_valid = '0;
   logic [NR*8-1:0] t_req_n     = '0;
   logic [NR-1:0]   t_req_ready, t_rsp_valid;
   logic [7:0]      t_rsp_result, t_eng_n;
   logic [7:0]      t_eng_result = 8'hA5;
   logic [1:0]      t_rsp_err;
   logic            t_eng_strobe;
   logic            t_eng_busy = 1'b1;

   fib_arbiter #(.NUM_REQ(NR), .N_WIDTH(8), .RES_WIDTH(8), .MAX_N(13), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .eng_strobe(eng_strobe), .eng_n(eng_n), .eng_busy(eng_busy), .eng_result(eng_result)
   );

   fib_arbiter #(.NUM_REQ(NR), .N_WIDTH(8), .RES_WIDTH(8), .MAX_N(13), .TIMEOUT(8)) dut_to (
      .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_n(t_req_n), .req_ready(t_req_ready),
      .rsp_valid(t_rsp_valid), .rsp_result(t_rsp_result), .rsp_err(t_rsp_err),
      .eng_strobe(t_eng_strobe), .eng_n(t_eng_n), .eng_busy(t_eng_busy), .eng_result(t_eng_result)
   );

   function automatic logic [7:0] fib(input logic [7:0] n);
      logic [7:0] a, b, t;
      a = 8'd0;
      b = 8'd1;
      for (int k = 0; k < int'(n); k++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Engine model: busy rises the cycle after strobe and stays high for n+1 cycles.
   always @(posedge clk) begin
      if (rst) begin
         eng_busy <= 1'b0;
         eng_rem  <= '0;
      end else if (eng_strobe) begin
         eng_busy <= 1'b1;
         eng_rem  <= eng_n;
      end else if (eng_busy) begin
         if (eng_rem == 8'd0) begin
            eng_busy   <= 1'b0;
            eng_result <= fib(eng_n);
         end else begin
            eng_rem <= eng_rem - 8'd1;
         end
      end
   end

   int cyc = 0;
   int strobe_cnt = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (eng_strobe) strobe_cnt <= strobe_cnt + 1;
   end

   int viol = 0;
   int rsp_seen = 0;
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (!$onehot0(rsp_valid) || !$onehot0(req_ready) ||
             !$onehot0(t_rsp_valid) || !$onehot0(t_req_ready)) viol = viol + 1;
         if (rsp_valid != '0) rsp_seen = rsp_seen + 1;
         if (t_rsp_valid != '0) rsp_seen = rsp_seen + 1;
      end
   end

   typedef struct {
      int         idx;
      logic [7:0] res;
      logic [1:0] err;
      int         lat;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_served = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit to, input int i, input int n);
      if (to) begin
         t_req_valid[i]     = 1'b1;
         t_req_n[i*8 +: 8]  = 8'(n);
      end else begin
         req_valid[i]       = 1'b1;
         req_n[i*8 +: 8]    = 8'(n);
      end
   endtask

   task automatic wait_ready(input bit to, input int i, output int g);
      logic [NR-1:0] rdy;
      int k;
      k = 0;
      rdy = to ? t_req_ready : req_ready;
      while (rdy == '0 && k < 300) begin
         @(negedge clk);
         #1;
         k++;
         rdy = to ? t_req_ready : req_ready;
      end
      chk("grant", 32'(rdy), 32'(1 << i));
      g = cyc;
   endtask

   task automatic serve(input bit to, input int i, input int n, input logic [7:0] res,
                        input logic [1:0] err, input int lat, output int g);
      exp_t e;
      logic [NR-1:0] rv;
      int k, r;
      wait_ready(to, i, g);
      sb.push_back('{idx: i, res: res, err: err, lat: lat});
      n_served++;
      @(negedge clk);
      if (to) t_req_valid[i] = 1'b0;
      else    req_valid[i]   = 1'b0;
      #1;
      chk("strobe", 32'(to ? t_eng_strobe : eng_strobe), 32'(lat > 1));
      if (lat > 1) chk("eng_n", 32'(to ? t_eng_n : eng_n), 32'(n));
      k = 0;
      rv = to ? t_rsp_valid : rsp_valid;
      while (rv == '0 && k < 400) begin
         @(negedge clk);
         #1;
         k++;
         rv = to ? t_rsp_valid : rsp_valid;
      end
      r = cyc;
      e = sb.pop_front();
      chk("rsp_valid", 32'(rv), 32'(1 << e.idx));
      chk("rsp_result", 32'(to ? t_rsp_result : rsp_result), 32'(e.res));
      chk("rsp_err", 32'(to ? t_rsp_err : rsp_err), 32'(e.err));
      chk("latency", 32'(r - g), 32'(e.lat));
      @(negedge clk);
      #1;
      chk("rsp_pulse", 32'(to ? t_rsp_valid : rsp_valid), 32'(0));
      chk("rsp_hold", 32'(to ? t_rsp_result : rsp_result), 32'(e.res));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req_valid   = '0;
      t_req_valid = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int g0, g1, gr, sc;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_strobe", 32'(eng_strobe), 32'(0));
      chk("rst_eng_n", 32'(eng_n), 32'(0));
      chk("rst_rsp_result", 32'(rsp_result), 32'(0));
      chk("rst_rsp_err", 32'(rsp_err), 32'(0));
      chk("rst_t_rsp_valid", 32'(t_rsp_valid), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      #1;

      // Single request after reset
      drive(0, 0, 10);
      #1;
      serve(0, 0, 10, 8'd55, ERR_OK, 14, g0);

      // All four at once from reset: strict 0,1,2,3 order, one grant per 12 cycles
      pulse_reset();
      for (int i = 0; i < NR; i++) drive(0, i, 7);
      #1;
      serve(0, 0, 7, 8'd13, ERR_OK, 11, g0);
      for (int i = 1; i < NR; i++) begin
         serve(0, i, 7, 8'd13, ERR_OK, 11, g1);
         chk("grant_spacing", 32'(g1 - g0), 32'(12));
         g0 = g1;
      end

      // Wrap: 3 was last served, so 0 wins over 3; n=13 is the largest legal index
      drive(0, 0, 12);
      drive(0, 3, 13);
      #1;
      serve(0, 0, 12, 8'd144, ERR_OK, 16, g0);
      serve(0, 3, 13, 8'd233, ERR_OK, 17, g0);

      // Range errors never touch the engine
      sc = strobe_cnt;
      drive(0, 2, 14);
      #1;
      serve(0, 2, 14, 8'd0, ERR_RANGE, 1, g0);
      drive(0, 1, 255);
      #1;
      serve(0, 1, 255, 8'd0, ERR_RANGE, 1, g0);
      chk("range_no_strobe", 32'(strobe_cnt), 32'(sc));

      // Reset while the engine is busy
      drive(0, 1, 10);
      #1;
      wait_ready(0, 1, gr);
      @(negedge clk);
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("mid_wait_busy", 32'(eng_busy), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("mid_rst_strobe", 32'(eng_strobe), 32'(0));
      chk("mid_rst_eng_n", 32'(eng_n), 32'(0));
      chk("mid_rst_rsp_result", 32'(rsp_result), 32'(0));
      chk("mid_rst_rsp_err", 32'(rsp_err), 32'(0));
      chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
      rst = 1'b0;
      drive(0, 3, 3);
      drive(0, 0, 5);
      #1;
      serve(0, 0, 5, 8'd5, ERR_OK, 9, g0);
      serve(0, 3, 3, 8'd2, ERR_OK, 7, g0);

      // Stuck-busy engine on the TIMEOUT=8 instance, then a quick engine
      drive(1, 1, 5);
      #1;
      serve(1, 1, 5, 8'd0, ERR_TIMEOUT, 11, g0);
      t_eng_busy = 1'b0;
      drive(1, 2, 3);
      #1;
      serve(1, 2, 3, 8'hA5, ERR_OK, 4, g0);

      repeat (3) @(negedge clk);
      #1;
      chk("onehot_violations", 32'(viol), 32'(0));
      chk("response_count", 32'(rsp_seen), 32'(n_served));
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d required below 20000", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
